// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Covers FSM states, ALU and operand-select codes, and data-processing command decode.
package multicycle_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
   } state_t;

   localparam state_t RESET_STATE = FETCH;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_EOR = 4'b0100;
   localparam logic [3:0] ALU_MOV = 4'b0101;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   typedef enum logic [3:0] {
      COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
      COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
   } cond_t;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   typedef struct packed {
      logic       ok;     // supported command
      logic       arith;  // C and V are meaningful
      logic       cmp;    // flags only, no register write
      logic [3:0] alu;
   } dp_dec_t;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_control;
      logic [1:0] imm_src;
      logic [1:0] reg_src;
   } ctrl_t;

   function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
      dp_dec_t d;
      d = '{ok: 1'b1, arith: 1'b0, cmp: 1'b0, alu: ALU_ADD};
      case (cmd)
         CMD_ADD: d.arith = 1'b1;
         CMD_SUB: begin d.alu = ALU_SUB; d.arith = 1'b1; end
         CMD_AND: d.alu = ALU_AND;
         CMD_ORR: d.alu = ALU_ORR;
         CMD_EOR: d.alu = ALU_EOR;
         CMD_MOV: d.alu = ALU_MOV;
         CMD_CMP: begin d.alu = ALU_SUB; d.arith = 1'b1; d.cmp = 1'b1; end
         default: d.ok = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the datapath.
interface multicycle_controller_if;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [3:0] Flags;

   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
   );

   modport master (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags
   );
endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flags register with gated writes and condition-code evaluation.
module cond_unit
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic [1:0] i_flag_w,    // [1]: N,Z  [0]: C,V
   output logic       o_cond_ex,
   output logic [3:0] o_flags
);
   logic [3:0] r_flags;
   logic       w_n, w_z, w_c, w_v;
   logic       w_cond_ex;

   assign {w_n, w_z, w_c, w_v} = r_flags;

   always_comb begin
      w_cond_ex = 1'b0;
      case (cond_t'(i_cond))
         COND_EQ: w_cond_ex = w_z;
         COND_NE: w_cond_ex = ~w_z;
         COND_CS: w_cond_ex = w_c;
         COND_CC: w_cond_ex = ~w_c;
         COND_MI: w_cond_ex = w_n;
         COND_PL: w_cond_ex = ~w_n;
         COND_VS: w_cond_ex = w_v;
         COND_VC: w_cond_ex = ~w_v;
         COND_HI: w_cond_ex = w_c & ~w_z;
         COND_LS: w_cond_ex = ~w_c | w_z;
         COND_GE: w_cond_ex = (w_n == w_v);
         COND_LT: w_cond_ex = (w_n != w_v);
         COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
         COND_LE: w_cond_ex = w_z | (w_n != w_v);
         COND_AL: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= 4'b0000;
      end else begin
         if (i_flag_w[1] && w_cond_ex) r_flags[3:2] <= i_alu_flags[3:2];
         if (i_flag_w[0] && w_cond_ex) r_flags[1:0] <= i_alu_flags[1:0];
      end
   end

   assign o_cond_ex = w_cond_ex;
   assign o_flags   = r_flags;
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM plus per-state datapath enables and selects.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.slave bus
);
   state_t     r_state;
   dp_dec_t    w_dp;
   ctrl_t      w_ctl;
   logic       w_cond_ex;
   logic [1:0] w_flag_w;
   logic       w_dp_we;
   logic       w_exec;

   assign w_dp    = dp_decode(bus.Funct[4:1]);
   assign w_exec  = (r_state == EXECUTER) || (r_state == EXECUTEI);
   assign w_dp_we = w_cond_ex & w_dp.ok & ~w_dp.cmp;

   // CMP writes flags regardless of S; unsupported commands write nothing.
   always_comb begin
      w_flag_w = 2'b00;
      if (w_exec && !rst && w_dp.ok && (bus.Funct[0] || w_dp.cmp))
         w_flag_w = {1'b1, w_dp.arith};
   end

   cond_unit u_cond (
      .clk         (clk),
      .rst         (rst),
      .i_cond      (bus.Cond),
      .i_alu_flags (bus.ALUFlags),
      .i_flag_w    (w_flag_w),
      .o_cond_ex   (w_cond_ex),
      .o_flags     (bus.Flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RESET_STATE;
      end else begin
         case (r_state)
            FETCH:  r_state <= DECODE;
            DECODE: begin
               case (bus.Op)
                  OP_MEM:  r_state <= MEMADR;
                  OP_DP:   r_state <= bus.Funct[5] ? EXECUTEI : EXECUTER;
                  OP_BR:   r_state <= BRANCH;
                  default: r_state <= FETCH;
               endcase
            end
            MEMADR:   r_state <= bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    r_state <= MEMWB;
            EXECUTER: r_state <= ALUWB;
            EXECUTEI: r_state <= ALUWB;
            default:  r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      w_ctl = '0;
      case (r_state)
         FETCH: begin
            w_ctl.ir_write    = 1'b1;
            w_ctl.pc_write    = 1'b1;
            w_ctl.alu_src_a   = 1'b1;
            w_ctl.alu_src_b   = SRCB_FOUR;
            w_ctl.alu_control = ALU_ADD;
            w_ctl.result_src  = RES_ALU;
         end
         DECODE: begin
            w_ctl.alu_src_a   = 1'b1;
            w_ctl.alu_src_b   = SRCB_FOUR;
            w_ctl.alu_control = ALU_ADD;
            w_ctl.result_src  = RES_ALU;
            w_ctl.reg_src     = {(bus.Op == OP_MEM) && !bus.Funct[0], bus.Op == OP_BR};
         end
         MEMADR: begin
            w_ctl.alu_src_b   = SRCB_IMM;
            w_ctl.alu_control = bus.Funct[3] ? ALU_ADD : ALU_SUB;
            w_ctl.imm_src     = IMM_MEM;
         end
         MEMRD: w_ctl.adr_src = 1'b1;
         MEMWB: begin
            w_ctl.result_src = RES_DATA;
            w_ctl.reg_write  = w_cond_ex;
         end
         MEMWR: begin
            w_ctl.adr_src   = 1'b1;
            w_ctl.mem_write = w_cond_ex;
         end
         EXECUTER: begin
            w_ctl.alu_src_b   = SRCB_WD;
            w_ctl.alu_control = w_dp.alu;
         end
         EXECUTEI: begin
            w_ctl.alu_src_b   = SRCB_IMM;
            w_ctl.imm_src     = IMM_DP;
            w_ctl.alu_control = w_dp.alu;
         end
         ALUWB: begin
            w_ctl.result_src = RES_ALUOUT;
            w_ctl.reg_write  = w_dp_we;
            w_ctl.pc_write   = w_dp_we && (bus.Rd == 4'd15);
         end
         BRANCH: begin
            w_ctl.alu_src_b  = SRCB_IMM;
            w_ctl.imm_src    = IMM_BR;
            w_ctl.result_src = RES_ALU;
            w_ctl.reg_src    = 2'b01;
            w_ctl.pc_write   = w_cond_ex;
         end
         default: w_ctl = '0;
      endcase
   end

   // Reset forces every state-changing enable low, even mid-instruction.
   assign bus.PCWrite    = w_ctl.pc_write  & ~rst;
   assign bus.MemWrite   = w_ctl.mem_write & ~rst;
   assign bus.IRWrite    = w_ctl.ir_write  & ~rst;
   assign bus.RegWrite   = w_ctl.reg_write & ~rst;
   assign bus.AdrSrc     = w_ctl.adr_src;
   assign bus.ResultSrc  = w_ctl.result_src;
   assign bus.ALUSrcA    = w_ctl.alu_src_a;
   assign bus.ALUSrcB    = w_ctl.alu_src_b;
   assign bus.ALUControl = w_ctl.alu_control;
   assign bus.ImmSrc     = w_ctl.imm_src;
   assign bus.RegSrc     = w_ctl.reg_src;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit that sequences the ARMv4 datapath as a multicycle machine. A single shared instruction/data memory, a 32-bit ALU and the register file are reused over 3-5 cycles per instruction.
- Replaces the single-cycle control path.
  - Owns the main FSM, the NZCV flags register and condition evaluation.
  - Drives every enable and mux select of the datapath.
- Sits beside the datapath. Inputs come from the instruction register (IR) fields and from the ALU flags.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed by the shared package).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Cond  in  4  IR[31:28]
- Op  in  2  IR[27:26]
- Funct  in  6  IR[25:20]
- Rd  in  4  IR[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, combinational, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALU result register
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result direct
- ALUSrcA  out  1  0=RD1 reg, 1=PC
- ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
- ALUControl  out  4  ALU operation code
- ImmSrc  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
- RegSrc  out  2  bit0: RA1=15; bit1: RA2=Rd
- Flags  out  4  registered NZCV, for debug/verification

Behaviour:
- State flow:
  - FETCH -> DECODE.
  - DECODE -> MEMADR when Op=01; EXECUTER when Op=00 and Funct[5]=0; EXECUTEI when Op=00 and Funct[5]=1; BRANCH when Op=10; FETCH when Op=11 (illegal, no side effects).
  - MEMADR -> MEMRD when Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Cycles per instruction: data-processing 4, LDR 5, STR 4, B 3, illegal 2.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional PC+4).
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. Produces PC+8 for the R15 read. RegSrc is set from Op: bit0=1 for branch, bit1=1 for STR.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD when Funct[3] (U)=1, SUB otherwise, ImmSrc=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWR: AdrSrc=1, MemWrite=CondEx.
- EXECUTER: ALUSrcB=00. EXECUTEI: ALUSrcB=01, ImmSrc=00. Both decode ALUControl from Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP (uses SUB code).
  - Any other cmd uses ADD with writes suppressed.
- ALUWB: ResultSrc=00, RegWrite=CondEx and cmd is not CMP. If Rd=15 with RegWrite, PCWrite=CondEx as well.
- BRANCH: ALUSrcA=0 with RA1=15, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=CondEx.
- Flags register (4b, reset 0000) updates at the end of EXECUTER/EXECUTEI only, when CondEx=1 and S=Funct[0]=1.
  - N,Z always update.
  - C,V update only for ADD/SUB/CMP.
  - CMP updates flags regardless of S.
- CondEx is combinational from Cond and the registered Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 is treated as 0
- Any output not listed for a state is 0.
- Reset: while rst=1 all enables (PCWrite, MemWrite, IRWrite, RegWrite) are 0. The state is loaded with FETCH and Flags with 0 at the clock edge. Reset asserted mid-instruction aborts it with no write in that cycle. The first FETCH occurs in the cycle after rst deasserts.
- Flags written in the ALUWB predecessor cycle are visible to the next instruction's CondEx. No forwarding is needed.

Decomposition:
- Package multicycle_pkg contains:
  - state_t enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  - ALU codes: ADD=0000, SUB=0001, AND=0010, ORR=0011, EOR=0100, MOV=0101
  - Op constants: DP=00, MEM=01, BR=10
  - cond_t codes
  - ResultSrc/ALUSrcB encodings
- One sub-module, cond_unit: holds the Flags register, the FlagW gating and the CondEx logic.

Test Plan:
- Reset for 2 cycles, then release. Require PCWrite=IRWrite=RegWrite=MemWrite=0 during reset, FETCH on the first cycle after release, and Flags=0000.
- Instr 0xE0821003 (ADD R1,R2,R3): states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=0000 in EXECUTER, RegWrite=1 only in ALUWB, Flags unchanged.
- 0xE5901004 (LDR) takes 5 cycles with AdrSrc=1 in MEMRD and RegWrite only in MEMWB. 0xE5801004 (STR) takes 4 cycles with MemWrite=1 only in MEMWR and RegSrc[1]=1.
- 0xE2500001 (SUBS R0,R0,#1) with ALUFlags=0100 in EXECUTEI gives Flags=0100 after ALUWB. A following 0x0A000002 (BEQ) asserts PCWrite in BRANCH.
- With Flags=0000, 0x0A000002 (BEQ) gives PCWrite=0 in BRANCH and returns to FETCH. 0xEA000002 (B) gives PCWrite=1.
- 0xEC000000 (Op=11) goes DECODE -> FETCH with no writes. Asserting rst during MEMWR gives MemWrite=0 and FETCH after release.
